hart_fetch: RTL and testbench
=============================

Name: hart_fetch

Overview:
- Instruction-fetch stage of the 4-hart barrel pipeline; sits directly upstream of the decode stage.
- Holds one PC per hart and picks a hart round-robin each cycle, skipping disabled harts.
- Drives the instruction-memory address and registers the IF/ID pipeline outputs consumed by decode.
- Applies branch/jump redirects reported by decode to the PC of the hart that produced them.

Parameters:
- RESET_PC, 32'h0000_0000, PC of hart 0 after reset.
- HART_STRIDE, 32'h0000_0400, reset PC of hart h is RESET_PC + h*HART_STRIDE.
- NOP_INSTR, 32'h0000_0013, instruction word inserted as a bubble (addi x0,x0,0).

Ports:
- clk  in  1  clock, all state on rising edge.
- nReset  in  1  asynchronous active-low reset.
- hart_en  in  4  per-hart enable; a 0 bit removes that hart from scheduling.
- stall  in  1  hazard stall; freezes PCs, scheduler pointer and IF/ID register.
- branch_ID  in  1  taken conditional branch resolved in decode.
- jump_ID  in  1  jal/jalr in decode.
- RBranch_EX  in  32  branch target from decode.
- absolute_jump_ID  in  32  jump target from decode.
- redirect_hart  in  2  hart ID of the instruction in decode (mhartID_ID fed back).
- imem_addr  out  32  word-aligned fetch address (combinational).
- imem_rdata  in  32  instruction word, valid in the same cycle as imem_ready.
- imem_ready  in  1  memory has data this cycle; 0 = wait state.
- I_ID  out  32  registered instruction.
- currentPC_ID  out  32  registered PC of I_ID.
- newpc_ID  out  32  registered currentPC_ID+4.
- mhartID_ID  out  2  registered hart ID of I_ID.
- IntmhartID  out  32  {30'b0, mhartID_ID}.
- valid_ID  out  1  1 = I_ID is a real fetched instruction.

Behaviour:
- Reset:
  - pc[h] = RESET_PC + h*HART_STRIDE.
  - rr_ptr = 3, so hart 0 is fetched first.
  - I_ID = NOP_INSTR; currentPC_ID = 0; newpc_ID = 0; mhartID_ID = 0; valid_ID = 0.
  - Reset mid-operation discards all state immediately.
- Selection (combinational):
  - sel = first h with hart_en[h]=1, searching rr_ptr+1, rr_ptr+2, ... modulo 4.
  - If hart_en = 0, there is no selection.
  - imem_addr = {pc[sel][31:2], 2'b00}; 0 when there is no selection.
- Redirect:
  - redirect = jump_ID | branch_ID. Target is absolute_jump_ID if jump_ID, else RBranch_EX; jump has priority if both are set.
  - pc[redirect_hart] <= target at the edge, even during stall. A redirect must not be lost.
- Normal cycle (stall=0, selection exists, imem_ready=1):
  - IF/ID <= {imem_rdata, pc[sel], pc[sel]+4, sel}; valid_ID <= 1.
  - pc[sel] <= pc[sel]+4, wrapping modulo 2^32; rr_ptr <= sel.
- Squash: a fetch with redirect=1 and sel==redirect_hart is squashed.
  - IF/ID gets NOP_INSTR, valid_ID=0.
  - pc[sel] takes the redirect target, not +4.
  - rr_ptr <= sel.
- Wait state (stall=0, imem_ready=0): IF/ID gets a bubble (NOP_INSTR, valid_ID=0); PCs other than a redirect are unchanged; rr_ptr unchanged.
- No selection: IF/ID gets a bubble; rr_ptr unchanged.
- Stall=1: IF/ID, rr_ptr and non-redirected PCs hold; imem_addr still driven.
- Disabling: clearing a hart_en bit takes effect on the next selection; that hart's PC is retained.
- Latency: instruction appears on I_ID one cycle after its address is presented with imem_ready=1.

Optional Feature:
- Macro: HART_FETCH_PERF_EN.
- Defined:
  - Adds output fetch_cnt (4x32, packed as 128).
  - fetch_cnt[h] increments on each valid_ID=1 load for hart h; reset 0; wraps at 2^32.
  - Also adds bubble_cnt (32), which increments on every bubble load.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package hart_pkg:
  - NHARTS=4, hart_id_t (logic [1:0]), NOP_INSTR constant.
  - function reset_pc(h).
  - typedef if_id_t struct {instr, pc, newpc, hart, valid}.
- Sub-module rr_hart_arbiter: inputs hart_en, rr_ptr; outputs sel, any. Purely combinational priority rotate, reused by later thread-scheduling blocks.

Test Plan:
- Reset, hart_en=4'b1111, imem_ready=1 → mhartID_ID sequence 0,1,2,3,0 with PCs 0x0, 0x400, 0x800, 0xC00, then 0x4; valid_ID=1 from cycle 1.
- hart_en=4'b0101 → sequence alternates 0,2,0,2; harts 1 and 3 PCs stay at 0x400 and 0xC00.
- Single hart (hart_en=4'b0001): jump_ID=1, redirect_hart=0, absolute_jump_ID=0x100 while fetching 0x8 → next I_ID is NOP with valid_ID=0; following fetch PC=0x100.
- All harts enabled: branch_ID=1, redirect_hart=1, RBranch_EX=0x480 while hart 3 fetches → hart 3 fetch valid; next hart-1 fetch PC=0x480.
- imem_ready=0 for 2 cycles, then stall=1 for 1 cycle → two bubbles, then IF/ID held. Resumes with the same hart and PC; no PC skipped.
- nReset asserted mid-stream → outputs immediately NOP/0/valid 0; hart 0 restarts at 0x0.

Source files
------------

// File: rtl/hart_pkg.sv
// Purpose : shared types and helpers for the barrel-hart front end.
// Latency : n/a (package only).
// Backpressure: n/a.
// Contents: NHARTS, hart_id_t, NOP_INSTR, if_id_t (IF/ID payload), reset_pc(), bubble().
package hart_pkg;

  localparam int NHARTS = 4;

  typedef logic [1:0] hart_id_t;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // IF/ID pipeline register payload
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] newpc;
    hart_id_t    hart;
    logic        valid;
  } if_id_t;

  // Boot PC of hart h: each hart gets its own stride-sized code window.
  function automatic logic [31:0] reset_pc(input hart_id_t    h,
                                           input logic [31:0] base,
                                           input logic [31:0] stride);
    return base + stride * {30'b0, h};
  endfunction

  // Pipeline bubble: NOP word, not a real instruction.
  function automatic if_id_t bubble(input logic [31:0] nop);
    if_id_t b;
    b.instr = nop;
    b.pc    = '0;
    b.newpc = '0;
    b.hart  = '0;
    b.valid = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/hart_fetch_rr_arbiter.sv
// Purpose : round-robin hart picker; first enabled hart after rr_ptr, wrapping.
// Latency : purely combinational, zero cycles.
// Backpressure: none; caller decides whether to advance rr_ptr.
// Ports: hart_en_i (enable mask), rr_ptr_i (last served hart),
//        sel_o (chosen hart, 0 when none), any_o (a hart was chosen).
module rr_hart_arbiter
  import hart_pkg::*;
(
  input  logic [NHARTS-1:0] hart_en_i,
  input  hart_id_t          rr_ptr_i,
  output hart_id_t          sel_o,
  output logic              any_o
);

  hart_id_t cand;

  // Candidates in order rr_ptr+1 .. rr_ptr+4; the last one is rr_ptr itself
  // (the 2-bit add wraps), so a lone enabled hart is picked every cycle.
  always_comb begin
    sel_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NHARTS; i++) begin
      cand = rr_ptr_i + hart_id_t'(i);
      if (!any_o && hart_en_i[cand]) begin
        sel_o = cand;
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hart_fetch.sv
// Purpose : 4-hart barrel fetch stage; per-hart PCs, round-robin pick, IF/ID register.
// Latency : instruction on I_ID one cycle after its address is presented with imem_ready=1.
// Backpressure: stall freezes PCs/pointer/IF/ID (redirects still land); imem_ready=0 inserts bubbles.
// Ports: clk, nReset (async active-low); hart_en; stall; branch_ID/jump_ID with
//        RBranch_EX/absolute_jump_ID targets and redirect_hart; imem_addr/imem_rdata/imem_ready;
//        IF/ID outputs I_ID, currentPC_ID, newpc_ID, mhartID_ID, IntmhartID, valid_ID.
// Optional: define HART_FETCH_PERF_EN to add fetch_cnt (4x32 packed) and bubble_cnt.
module hart_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] HART_STRIDE = 32'h0000_0400,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic [3:0]   hart_en,
  input  logic         stall,
  input  logic         branch_ID,
  input  logic         jump_ID,
  input  logic [31:0]  RBranch_EX,
  input  logic [31:0]  absolute_jump_ID,
  input  logic [1:0]   redirect_hart,
  output logic [31:0]  imem_addr,
  input  logic [31:0]  imem_rdata,
  input  logic         imem_ready,
  output logic [31:0]  I_ID,
  output logic [31:0]  currentPC_ID,
  output logic [31:0]  newpc_ID,
  output logic [1:0]   mhartID_ID,
  output logic [31:0]  IntmhartID,
  output logic         valid_ID
`ifdef HART_FETCH_PERF_EN
  ,
  output logic [127:0] fetch_cnt,
  output logic [31:0]  bubble_cnt
`endif
);

  import hart_pkg::*;

  logic [31:0] pc_q [NHARTS];
  logic [31:0] pc_d [NHARTS];
  hart_id_t    rr_ptr_q, rr_ptr_d;
  if_id_t      ifid_q, ifid_d;

  hart_id_t    sel;
  logic        any;
  logic        redirect;
  logic [31:0] target;
  logic        fetch_go;

  rr_hart_arbiter u_arb (
    .hart_en_i (hart_en),
    .rr_ptr_i  (rr_ptr_q),
    .sel_o     (sel),
    .any_o     (any)
  );

  always_comb begin
    redirect  = jump_ID | branch_ID;
    target    = jump_ID ? absolute_jump_ID : RBranch_EX;
    imem_addr = any ? {pc_q[sel][31:2], 2'b00} : 32'h0;
    fetch_go  = !stall && any && imem_ready;

    pc_d     = pc_q;
    rr_ptr_d = rr_ptr_q;
    ifid_d   = ifid_q;

    if (!stall) begin
      if (fetch_go) begin
        rr_ptr_d  = sel;
        pc_d[sel] = pc_q[sel] + 32'd4;
        // The instruction in decode redirects this very hart, so the word
        // being fetched is on the wrong path: replace it with a bubble.
        if (redirect && (sel == redirect_hart)) begin
          ifid_d = bubble(NOP_INSTR);
        end else begin
          ifid_d.instr = imem_rdata;
          ifid_d.pc    = pc_q[sel];
          ifid_d.newpc = pc_q[sel] + 32'd4;
          ifid_d.hart  = sel;
          ifid_d.valid = 1'b1;
        end
      end else begin
        ifid_d = bubble(NOP_INSTR);
      end
    end

    // Redirect is applied last so it overrides the +4 of a squashed fetch,
    // and is independent of stall so that it can never be dropped.
    if (redirect) begin
      pc_d[redirect_hart] = target;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      for (int h = 0; h < NHARTS; h++) begin
        pc_q[h] <= reset_pc(hart_id_t'(h), RESET_PC, HART_STRIDE);
      end
      rr_ptr_q <= hart_id_t'(NHARTS - 1);  // hart 0 goes first
      ifid_q   <= bubble(NOP_INSTR);
    end else begin
      pc_q     <= pc_d;
      rr_ptr_q <= rr_ptr_d;
      ifid_q   <= ifid_d;
    end
  end

  assign I_ID         = ifid_q.instr;
  assign currentPC_ID = ifid_q.pc;
  assign newpc_ID     = ifid_q.newpc;
  assign mhartID_ID   = ifid_q.hart;
  assign IntmhartID   = {30'b0, ifid_q.hart};
  assign valid_ID     = ifid_q.valid;

`ifdef HART_FETCH_PERF_EN
  logic [31:0] fetch_cnt_q [NHARTS];
  logic [31:0] bubble_cnt_q;

  // Every non-stalled cycle loads IF/ID with either a real fetch or a bubble.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      for (int h = 0; h < NHARTS; h++) begin
        fetch_cnt_q[h] <= '0;
      end
      bubble_cnt_q <= '0;
    end else if (!stall) begin
      if (ifid_d.valid) begin
        fetch_cnt_q[ifid_d.hart] <= fetch_cnt_q[ifid_d.hart] + 32'd1;
      end else begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
    end
  end

  for (genvar g = 0; g < NHARTS; g++) begin : g_cnt
    assign fetch_cnt[g*32 +: 32] = fetch_cnt_q[g];
  end
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_hart_fetch.sv
// Purpose : self-checking bench for hart_fetch; random + directed stimulus vs a reference model.
// Latency : expected IF/ID content is queued per cycle and compared one edge later.
// Backpressure: exercises stall, imem wait states, squash and mid-stream reset.
module tb_hart_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        nReset;
  logic [3:0]  hart_en;
  logic        stall, branch_ID, jump_ID;
  logic [31:0] RBranch_EX, absolute_jump_ID;
  logic [1:0]  redirect_hart;
  logic [31:0] imem_addr, imem_rdata;
  logic        imem_ready;
  logic [31:0] I_ID, currentPC_ID, newpc_ID, IntmhartID;
  logic [1:0]  mhartID_ID;
  logic        valid_ID;
`ifdef HART_FETCH_PERF_EN
  logic [127:0] fetch_cnt;
  logic [31:0]  bubble_cnt;
`endif

  hart_fetch dut (
    .clk              (clk),
    .nReset           (nReset),
    .hart_en          (hart_en),
    .stall            (stall),
    .branch_ID        (branch_ID),
    .jump_ID          (jump_ID),
    .RBranch_EX       (RBranch_EX),
    .absolute_jump_ID (absolute_jump_ID),
    .redirect_hart    (redirect_hart),
    .imem_addr        (imem_addr),
    .imem_rdata       (imem_rdata),
    .imem_ready       (imem_ready),
    .I_ID             (I_ID),
    .currentPC_ID     (currentPC_ID),
    .newpc_ID         (newpc_ID),
    .mhartID_ID       (mhartID_ID),
    .IntmhartID       (IntmhartID),
    .valid_ID         (valid_ID)
`ifdef HART_FETCH_PERF_EN
    ,
    .fetch_cnt        (fetch_cnt),
    .bubble_cnt       (bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] newpc;
    logic [1:0]  hart;
    logic        valid;
  } exp_t;

  typedef struct {
    int          hart;
    logic [31:0] pc;
  } obs_t;

  exp_t sbq[$];
  obs_t obs[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: architectural PC per hart, last-served hart, IF/ID content.
  logic [31:0] m_pc [4];
  int          m_last;
  exp_t        m_ifid;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk_bubble();
    exp_t b;
    b.instr = NOP; b.pc = '0; b.newpc = '0; b.hart = '0; b.valid = 1'b0;
    return b;
  endfunction

  task automatic m_reset();
    for (int h = 0; h < 4; h++) m_pc[h] = 32'h400 * h;
    m_last = 3;
    m_ifid = mk_bubble();
  endtask

  // Monitor: after every edge, compare the IF/ID register to the queued expectation.
  always @(posedge clk) begin
    #1;
    if (nReset && sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      chk("I_ID", I_ID, mon_e.instr);
      chk("valid_ID", 32'(valid_ID), 32'(mon_e.valid));
      if (mon_e.valid) begin
        chk("currentPC_ID", currentPC_ID, mon_e.pc);
        chk("newpc_ID", newpc_ID, mon_e.newpc);
        chk("mhartID_ID", 32'(mhartID_ID), 32'(mon_e.hart));
        chk("IntmhartID", IntmhartID, 32'(mon_e.hart));
      end
      if (valid_ID === 1'b1) obs.push_back('{int'(mhartID_ID), currentPC_ID});
    end
  end

  // One cycle of stimulus: drive at negedge, check the fetch address, step the model.
  task automatic cyc(input logic [3:0] en, input logic st, input logic br, input logic jp,
                     input logic [31:0] rb, input logic [31:0] aj, input logic [1:0] rh,
                     input logic rdy);
    int          s;
    logic [31:0] npc [4];
    logic [31:0] word;
    @(negedge clk);
    word = $urandom;
    hart_en = en; stall = st; branch_ID = br; jump_ID = jp;
    RBranch_EX = rb; absolute_jump_ID = aj; redirect_hart = rh;
    imem_ready = rdy; imem_rdata = word;
    s = -1;
    for (int k = 1; k <= 4; k++) begin
      if (s < 0 && en[(m_last + k) % 4]) s = (m_last + k) % 4;
    end
    #1;
    chk("imem_addr", imem_addr, (s < 0) ? 32'h0 : (m_pc[s] & 32'hFFFF_FFFC));
    npc = m_pc;
    if (!st) begin
      if (s >= 0 && rdy) begin
        m_last = s;
        npc[s] = m_pc[s] + 32'd4;
        if ((br || jp) && int'(rh) == s) m_ifid = mk_bubble();
        else m_ifid = '{word, m_pc[s], m_pc[s] + 32'd4, s[1:0], 1'b1};
      end else begin
        m_ifid = mk_bubble();
      end
    end
    if (br || jp) npc[rh] = jp ? aj : rb;
    m_pc = npc;
    sbq.push_back(m_ifid);
  endtask

  task automatic run(input logic [3:0] en, input int n);
    for (int i = 0; i < n; i++) cyc(en, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
  endtask

  // Asynchronous reset away from the edge; outputs must clear at once.
  task automatic do_reset();
    @(posedge clk);
    #3;
    nReset = 1'b0;
    hart_en = 4'h0; stall = 1'b1; branch_ID = 1'b0; jump_ID = 1'b0; imem_ready = 1'b0;
    #1;
    chk("rst_I_ID", I_ID, NOP);
    chk("rst_valid", 32'(valid_ID), 32'h0);
    chk("rst_pc", currentPC_ID, 32'h0);
    chk("rst_newpc", newpc_ID, 32'h0);
    chk("rst_hart", IntmhartID, 32'h0);
    m_reset();
    obs.delete();
    sbq.delete();
    @(negedge clk);
    nReset = 1'b1;
  endtask

  task automatic drain();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_obs(input int idx, input int hart, input logic [31:0] pc);
    if (idx >= obs.size()) begin
      n_tests++;
      n_fail++;
      $display("FAIL obs_missing: got %0d fetches, required more than %0d", obs.size(), idx);
    end else begin
      chk($sformatf("obs%0d_hart", idx), 32'(obs[idx].hart), 32'(hart));
      chk($sformatf("obs%0d_pc", idx), obs[idx].pc, pc);
    end
  endtask

  initial begin
    nReset = 1'b0; hart_en = 4'h0; stall = 1'b0; branch_ID = 1'b0; jump_ID = 1'b0;
    RBranch_EX = '0; absolute_jump_ID = '0; redirect_hart = '0;
    imem_rdata = '0; imem_ready = 1'b0;
    m_reset();
    do_reset();

    // All harts, always ready: 0,1,2,3,0
    run(4'b1111, 5);
    drain();
    chk_obs(0, 0, 32'h0);
    chk_obs(1, 1, 32'h400);
    chk_obs(2, 2, 32'h800);
    chk_obs(3, 3, 32'hC00);
    chk_obs(4, 0, 32'h4);

    // Harts 0 and 2 only, then re-enable all: 1 and 3 kept their PCs
    run(4'b0101, 4);
    run(4'b1111, 4);
    drain();
    chk_obs(5, 2, 32'h804);
    chk_obs(6, 0, 32'h8);
    chk_obs(9, 1, 32'h404);
    chk_obs(11, 3, 32'hC04);

    // Reset mid-stream: hart 0 restarts at 0
    do_reset();
    run(4'b1111, 1);
    drain();
    chk_obs(0, 0, 32'h0);

    // Single hart, jump while fetching 0x8: squashed, then 0x100
    do_reset();
    run(4'b0001, 2);
    cyc(4'b0001, 1'b0, 1'b0, 1'b1, 32'h0, 32'h100, 2'd0, 1'b1);
    run(4'b0001, 2);
    drain();
    chk_obs(2, 0, 32'h100);
    chk_obs(3, 0, 32'h104);

    // Branch for hart 1 while hart 3 fetches; then wait states and a stall
    do_reset();
    run(4'b1111, 3);
    cyc(4'b1111, 1'b0, 1'b1, 1'b0, 32'h480, 32'h0, 2'd1, 1'b1);
    run(4'b1111, 2);
    cyc(4'b1111, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
    cyc(4'b1111, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
    cyc(4'b1111, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    run(4'b1111, 2);
    drain();
    chk_obs(3, 3, 32'hC00);
    chk_obs(5, 1, 32'h480);
    chk_obs(6, 2, 32'h804);
    chk_obs(7, 3, 32'hC04);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [3:0]  en;
      logic [31:0] aj;
      en = ($urandom_range(0, 9) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      aj = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom;
      cyc(en, $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
          $urandom, aj, 2'($urandom_range(0, 3)), $urandom_range(0, 4) != 0);
    end
    drain();
    chk("sb_drain", 32'(sbq.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
